mmio_bridge: RTL and testbench

MMIO_BRIDGE -- requirements
Module: mmio_bridge

---
 rtl/mmio_bridge.sv | 164 ++++++++++++++++
 tb/tb_mmio_bridge.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mmio_bridge.sv
// mmio_bridge: decodes the CPU data address into DMEM / IMEM / IO regions and
// implements the memory-mapped IO block: per-channel UART TX/RX byte buffers
// with ready/valid handshakes, status registers and a free-running cycle counter.
// IO loads are returned one cycle late to line up with synchronous DMEM reads.
module mmio_bridge #(
   parameter int NUM_CH = 2,
   parameter int CNT_W  = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [3:0]            StoreMask,
   input  logic                  LoadEn,
   input  logic [31:0]           MemMapAddress,
   input  logic [7:0]            IODataFromCPU,
   output logic [3:0]            StoreMaskDMEM,
   output logic [3:0]            StoreMaskIMEM,
   output logic                  LoadDMEMorIO,
   output logic [31:0]           DataFromIO,
   output logic [8*NUM_CH-1:0]   DataIn,
   output logic [NUM_CH-1:0]     DataInValid,
   input  logic [NUM_CH-1:0]     DataInReady,
   input  logic [8*NUM_CH-1:0]   DataOut,
   input  logic [NUM_CH-1:0]     DataOutValid,
   output logic [NUM_CH-1:0]     DataOutReady
);

   logic [3:0]             region;
   logic [3:0]             ch;
   logic [3:0]             off;
   logic                   is_dmem;
   logic                   is_imem;
   logic                   is_io;
   logic                   io_load;
   logic                   io_store;
   logic                   cnt_hit;
   logic                   cnt_clr;
   logic [NUM_CH-1:0]      tx_full;
   logic [NUM_CH-1:0]      tx_ovr;
   logic [NUM_CH-1:0]      rx_full;
   logic [NUM_CH-1:0]      tx_wr;
   logic [NUM_CH-1:0]      st_rd;
   logic [NUM_CH-1:0]      rx_rd;
   logic [NUM_CH-1:0]      tx_hs;
   logic [NUM_CH-1:0]      rx_cap;
   logic [NUM_CH-1:0][7:0] tx_data;
   logic [NUM_CH-1:0][7:0] rx_data;
   logic [CNT_W-1:0]       cnt;
   logic [31:0]            ch_data;
   logic [31:0]            rd_data;
   logic                   unused_addr;

   assign region      = MemMapAddress[31:28];
   assign ch          = MemMapAddress[7:4];
   assign off         = MemMapAddress[3:0];
   // Middle address bits take no part in decoding.
   assign unused_addr = ^MemMapAddress[27:8];

   assign DataInValid = tx_full;
   assign DataIn      = tx_data;

   // Region decode: DMEM wins over IMEM when both low region bits are set.
   always_comb begin
      is_dmem  = (region[3] == 1'b0) && (region[0] == 1'b1);
      is_imem  = (region[3] == 1'b0) && (region[1] == 1'b1) && (region[0] == 1'b0);
      is_io    = (region == 4'b1000);
      StoreMaskDMEM = is_dmem ? StoreMask : 4'b0000;
      StoreMaskIMEM = is_imem ? StoreMask : 4'b0000;
      io_load  = is_io & LoadEn;
      io_store = is_io & (StoreMask != 4'b0000);
      cnt_hit  = is_io && (ch == 4'hF) && (off == 4'h0);
      cnt_clr  = cnt_hit & io_store;
   end

   // Per-channel access strobes, handshakes and the IO read mux.
   always_comb begin
      tx_wr        = '0;
      st_rd        = '0;
      rx_rd        = '0;
      tx_hs        = '0;
      rx_cap       = '0;
      DataOutReady = '0;
      ch_data      = 32'd0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (is_io && (ch == 4'(c))) begin
            tx_wr[c] = io_store && (off == 4'h8);
            st_rd[c] = io_load && (off == 4'h0);
            rx_rd[c] = io_load && (off == 4'hC);
            case (off)
               4'h0:    ch_data = {29'd0, tx_ovr[c], ~tx_full[c] & DataInReady[c], ~tx_full[c]};
               4'h4:    ch_data = {31'd0, rx_full[c]};
               4'hC:    ch_data = rx_full[c] ? {24'd0, rx_data[c]} : 32'd0;
               default: ch_data = 32'd0;
            endcase
         end else begin
            tx_wr[c] = 1'b0;
            st_rd[c] = 1'b0;
            rx_rd[c] = 1'b0;
         end
         tx_hs[c]        = tx_full[c] & DataInReady[c];
         // A pop in progress blocks capture so the popped byte is never overwritten.
         DataOutReady[c] = ~rx_full[c] & ~rx_rd[c];
         rx_cap[c]       = DataOutValid[c] & DataOutReady[c];
      end
      if (cnt_hit) begin
         rd_data = 32'(cnt);
      end else begin
         rd_data = ch_data;
      end
   end

   // Per-channel TX holding register, overrun flag and RX latch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_full <= '0;
         tx_ovr  <= '0;
         rx_full <= '0;
         tx_data <= '0;
         rx_data <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (tx_wr[c] && (!tx_full[c] || tx_hs[c])) begin
               tx_full[c] <= 1'b1;
               tx_data[c] <= IODataFromCPU;
            end else if (tx_hs[c]) begin
               tx_full[c] <= 1'b0;
            end
            if (tx_wr[c] && tx_full[c] && !tx_hs[c]) begin
               tx_ovr[c] <= 1'b1;
            end else if (st_rd[c]) begin
               tx_ovr[c] <= 1'b0;
            end
            if (rx_cap[c]) begin
               rx_full[c] <= 1'b1;
               rx_data[c] <= DataOut[8*c +: 8];
            end else if (rx_rd[c]) begin
               rx_full[c] <= 1'b0;
            end
         end
      end
   end

   // Free-running cycle counter; a store to its address clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (cnt_clr) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Registered IO load return, one cycle behind LoadEn.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         LoadDMEMorIO <= 1'b0;
         DataFromIO   <= 32'd0;
      end else begin
         LoadDMEMorIO <= io_load;
         DataFromIO   <= io_load ? rd_data : 32'd0;
      end
   end

endmodule

// File: tb/tb_mmio_bridge.sv
// Randomized scoreboard bench for mmio_bridge with a behavioural model.
module tb_mmio_bridge;
   localparam int NUM_CH = 2;
   localparam int CNT_W  = 8;
   localparam int N_IT   = 3000;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [3:0]           StoreMask = 4'd0;
   logic                 LoadEn = 1'b0;
   logic [31:0]          MemMapAddress = 32'd0;
   logic [7:0]           IODataFromCPU = 8'd0;
   logic [3:0]           StoreMaskDMEM;
   logic [3:0]           StoreMaskIMEM;
   logic                 LoadDMEMorIO;
   logic [31:0]          DataFromIO;
   logic [8*NUM_CH-1:0]  DataIn;
   logic [NUM_CH-1:0]    DataInValid;
   logic [NUM_CH-1:0]    DataInReady = '0;
   logic [8*NUM_CH-1:0]  DataOut = '0;
   logic [NUM_CH-1:0]    DataOutValid = '0;
   logic [NUM_CH-1:0]    DataOutReady;

   mmio_bridge #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .StoreMask(StoreMask), .LoadEn(LoadEn),
      .MemMapAddress(MemMapAddress), .IODataFromCPU(IODataFromCPU),
      .StoreMaskDMEM(StoreMaskDMEM), .StoreMaskIMEM(StoreMaskIMEM),
      .LoadDMEMorIO(LoadDMEMorIO), .DataFromIO(DataFromIO),
      .DataIn(DataIn), .DataInValid(DataInValid), .DataInReady(DataInReady),
      .DataOut(DataOut), .DataOutValid(DataOutValid), .DataOutReady(DataOutReady)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   passed = 0;
   int   cyc = 0;
   bit   in_reset = 1'b1;

   // Model state: what software would believe about each channel.
   bit          tx_busy [NUM_CH];
   logic [7:0]  tx_byte [NUM_CH];
   bit          ovr     [NUM_CH];
   bit          rx_busy [NUM_CH];
   logic [7:0]  rx_byte [NUM_CH];
   int          zero_cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic drive_idle();
      StoreMask     = 4'd0;
      LoadEn        = 1'b0;
      MemMapAddress = 32'd0;
      DataInReady   = '0;
      DataOutValid  = '0;
   endtask

   // Monitor: registered load results, compared against the scoreboard queue.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (!in_reset) begin
            if (LoadDMEMorIO === 1'b1) begin
               if (sb.size() == 0) begin
                  check("io_sel_spurious", 32'(LoadDMEMorIO), 32'd0);
               end else begin
                  e = sb.pop_front();
                  check("load_latency", 32'(cyc), 32'(e.cyc + 1));
                  check("io_load_data", DataFromIO, e.data);
               end
            end else begin
               check("idle_data", DataFromIO, 32'd0);
               if (sb.size() > 0 && sb[0].cyc < cyc) begin
                  e = sb.pop_front();
                  check("io_sel_missing", 32'(LoadDMEMorIO), 32'd1);
               end
            end
         end
      end
   end

   // Stimulus and reference model.
   initial begin
      logic [3:0]  a, ch, off;
      logic [31:0] val;
      bit          is_io, is_dmem, is_imem, ld, st, rdy_exp, hs, wr;
      int          op, kind, chi;
      int          chs [6] = '{0, 1, 0, 1, 2, 7};
      logic [3:0]  offs [5] = '{4'h0, 4'h4, 4'h8, 4'hC, 4'h0};

      for (int it = 0; it < N_IT; it++) begin
         @(posedge clk);
         cyc++;
         #1;
         if (it == 0 || it == 1500) begin
            rst_n = 1'b0;
            in_reset = 1'b1;
            sb.delete();
            drive_idle();
            #1;
            check("rst_tx_valid", 32'(DataInValid), 32'd0);
            check("rst_tx_data", 32'(DataIn), 32'd0);
            check("rst_load_sel", 32'(LoadDMEMorIO), 32'd0);
            check("rst_load_data", DataFromIO, 32'd0);
            continue;
         end
         if (in_reset) begin
            rst_n = 1'b1;
            in_reset = 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
               tx_busy[c] = 1'b0;
               ovr[c]     = 1'b0;
               rx_busy[c] = 1'b0;
            end
            zero_cyc = cyc;
         end

         op = (it >= N_IT - 3) ? 9 : $urandom_range(0, 9);
         kind = $urandom_range(0, 9);
         offs[4] = 4'($urandom_range(0, 15));
         if (kind <= 5)
            MemMapAddress = {4'b1000, 20'($urandom), 4'(chs[$urandom_range(0, 5)]),
                             offs[$urandom_range(0, 4)]};
         else if (kind <= 7)
            MemMapAddress = {4'b1000, 20'($urandom), 4'hF, ($urandom_range(0, 3) == 0) ? 4'h4 : 4'h0};
         else
            MemMapAddress = $urandom;
         LoadEn        = (op <= 3);
         StoreMask     = (op >= 4 && op <= 6) ? 4'($urandom_range(1, 15)) : 4'd0;
         IODataFromCPU = 8'($urandom);
         for (int c = 0; c < NUM_CH; c++) begin
            DataInReady[c]     = ($urandom_range(0, 9) < 4);
            DataOutValid[c]    = ($urandom_range(0, 9) < 3);
            DataOut[8*c +: 8]  = 8'($urandom);
         end

         @(negedge clk);
         a   = MemMapAddress[31:28];
         ch  = MemMapAddress[7:4];
         off = MemMapAddress[3:0];
         is_io   = (a == 4'b1000);
         is_dmem = (a ==? 4'b0??1);
         is_imem = (a ==? 4'b0?1?) && !is_dmem;
         check("dmem_mask", 32'(StoreMaskDMEM), is_dmem ? 32'(StoreMask) : 32'd0);
         check("imem_mask", 32'(StoreMaskIMEM), is_imem ? 32'(StoreMask) : 32'd0);
         ld  = is_io && LoadEn;
         st  = is_io && (StoreMask != 4'd0);
         chi = int'(ch);

         if (ld) begin
            val = 32'd0;
            if (ch == 4'hF) begin
               if (off == 4'h0) val = 32'((cyc - zero_cyc) % (1 << CNT_W));
            end else if (chi < NUM_CH) begin
               case (off)
                  4'h0:    val = {29'd0, ovr[chi], !tx_busy[chi] && DataInReady[chi], !tx_busy[chi]};
                  4'h4:    val = {31'd0, rx_busy[chi]};
                  4'hC:    val = rx_busy[chi] ? {24'd0, rx_byte[chi]} : 32'd0;
                  default: val = 32'd0;
               endcase
            end
            sb.push_back('{cyc, val});
         end

         for (int c = 0; c < NUM_CH; c++) begin
            rdy_exp = !rx_busy[c] && !(ld && chi == c && off == 4'hC);
            check("rx_ready", 32'(DataOutReady[c]), 32'(rdy_exp));
            check("tx_valid", 32'(DataInValid[c]), 32'(tx_busy[c]));
            if (tx_busy[c]) check("tx_byte", 32'(DataIn[8*c +: 8]), 32'(tx_byte[c]));

            hs = tx_busy[c] && DataInReady[c];
            wr = st && chi == c && off == 4'h8;
            if (wr && (!tx_busy[c] || hs)) begin
               tx_busy[c] = 1'b1;
               tx_byte[c] = IODataFromCPU;
            end else if (wr) begin
               ovr[c] = 1'b1;
            end else if (hs) begin
               tx_busy[c] = 1'b0;
            end
            if (ld && chi == c && off == 4'h0 && !wr) ovr[c] = 1'b0;
            if (DataOutValid[c] && rdy_exp) begin
               rx_busy[c] = 1'b1;
               rx_byte[c] = DataOut[8*c +: 8];
            end else if (ld && chi == c && off == 4'hC) begin
               rx_busy[c] = 1'b0;
            end
         end
         if (st && ch == 4'hF && off == 4'h0) zero_cyc = cyc + 1;
      end

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
